// File: rtl/time_keeper.sv
// time_keeper -- 24-hour clock (hh:mm:ss) driven by a 1 kHz system clock.
//
// A prescaler divides clk_1kHz down to one tick per second while in run mode.
// In set mode, time is frozen with seconds cleared, and two debounced keys
// step minutes and hours independently.
//
// Ports:
//   clk_1kHz  in   system clock, all logic on its rising edge
//   rst       in   synchronous active-high reset
//   set_en    in   1 = set mode (time frozen, keys active), 0 = run mode
//   key_min   in   raw minute-set key, active-high, undebounced
//   key_hour  in   raw hour-set key, active-high, undebounced
//   seconds   out  0..59, registered
//   minutes   out  0..59, registered
//   hours     out  0..23, registered
//   sec_tick  out  one-cycle pulse on each run-mode second boundary
module time_keeper #(
  parameter int TICK_DIV    = 1000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic       clk_1kHz,
  input  logic       rst,
  input  logic       set_en,
  input  logic       key_min,
  input  logic       key_hour,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic       sec_tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  // The counter value at which the next differing sample is the
  // DEBOUNCE_MS-th consecutive one.
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_MS - 1);

  logic [PW-1:0] presc;
  logic [1:0]    key_raw;     // [0] = minute key, [1] = hour key
  logic [1:0]    key_stable;
  logic [DW-1:0] db_cnt [2];
  logic [1:0]    press;
  logic          tick_now;

  // Increment with wrap to 0 past 'last'; any out-of-range value also
  // returns to 0, so the counters can never leave their legal range.
  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] last);
    return (v >= last) ? 6'd0 : v + 6'd1;
  endfunction

  assign key_raw  = {key_hour, key_min};
  assign tick_now = !set_en && (presc == PRESC_LAST);

  // An accepted press is the stable level going 0->1 on this edge, so the
  // increment lands on the same edge the debouncer accepts the new level.
  always_comb begin
    press = 2'b00;
    for (int i = 0; i < 2; i++) begin
      press[i] = key_raw[i] && !key_stable[i] && (db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clk_1kHz) begin
    if (rst) begin
      presc      <= '0;
      sec_tick   <= 1'b0;
      seconds    <= 6'd0;
      minutes    <= 6'd0;
      hours      <= 5'd0;
      key_stable <= 2'b00;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      // Debouncers run in both modes.
      for (int i = 0; i < 2; i++) begin
        if (key_raw[i] == key_stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          key_stable[i] <= key_raw[i];
          db_cnt[i]     <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end

      if (set_en) begin
        // Set mode wins over a coincident terminal count: no tick.
        presc    <= '0;
        sec_tick <= 1'b0;
        seconds  <= 6'd0;
        if (press[0]) minutes <= inc_wrap(minutes, 6'd59);
        if (press[1]) hours   <= 5'(inc_wrap({1'b0, hours}, 6'd23));
      end else begin
        sec_tick <= tick_now;
        presc    <= tick_now ? '0 : presc + 1'b1;
        if (tick_now) begin
          seconds <= inc_wrap(seconds, 6'd59);
          if (seconds >= 6'd59) begin
            minutes <= inc_wrap(minutes, 6'd59);
            if (minutes >= 6'd59) hours <= 5'(inc_wrap({1'b0, hours}, 6'd23));
          end
        end
      end
    end
  end

endmodule
